seizure_decision: RTL

SEIZURE_DECISION -- requirements
Module: seizure_decision

---
 rtl/seizure_decision.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seizure_decision.sv
// seizure_decision: per-channel weighted feature vote with persistence alarm
// Ports: clk/rst (async active-high); en active-low stall; in_valid/in_ready/in_ch/feat_bus/base_bus
// sample handshake; out_valid/out_ch/out_sum result; alarm per-channel flag; err bad-channel pulse.
// Macro SEIZURE_DECISION_HYST_EN: sub-threshold results decrement the counter instead of clearing it.
module seizure_decision #(
  parameter int NUM_CH = 4,
  parameter int NUM_FEAT = 6,
  parameter int FEAT_W = 40,
  parameter int BASE_W = 52,
  parameter logic [NUM_FEAT*4-1:0] K_VEC = {NUM_FEAT{4'd8}},
  parameter logic [NUM_FEAT*8-1:0] WS_VEC = {NUM_FEAT{8'd2}},
  parameter logic signed [11:0] SUM_TH = 12'sd6,
  parameter int HOLD = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_ch,
  input  logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [NUM_FEAT*BASE_W-1:0] base_bus,
  output logic                       out_valid,
  output logic [3:0]                 out_ch,
  output logic [11:0]                out_sum,
  output logic [NUM_CH-1:0]          alarm,
  output logic                       err
);
  localparam int CW = (FEAT_W + 3 > BASE_W + 4) ? FEAT_W + 3 : BASE_W + 4;
  typedef enum logic [1:0] {IDLE, SUM, UPDATE} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic signed [11:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [NUM_FEAT*BASE_W-1:0] base_q, base_d;
  logic [3:0] ch_q, ch_d, out_ch_q, out_ch_d;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cnt_d [NUM_CH];
  logic accept, bad, hit;
  logic [CW-1:0] lhs, rhs;
  logic [7:0] ws;
  logic signed [12:0] add;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      feat_q <= '0;
      base_q <= '0;
      ch_q <= '0;
      out_ch_q <= '0;
      out_sum_q <= '0;
      out_valid_q <= 1'b0;
      err_q <= 1'b0;
      alarm_q <= '0;
      cnt_q <= '{default: 8'd0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      feat_q <= feat_d;
      base_q <= base_d;
      ch_q <= ch_d;
      out_ch_q <= out_ch_d;
      out_sum_q <= out_sum_d;
      out_valid_q <= out_valid_d;
      err_q <= err_d;
      alarm_q <= alarm_d;
      cnt_q <= cnt_d;
    end
  end
  // Feature idx_q compare, widened so neither the x8 nor the xK product can wrap.
  always_comb begin
    lhs = CW'(feat_q[idx_q*FEAT_W +: FEAT_W]) << 3;
    rhs = CW'(base_q[idx_q*BASE_W +: BASE_W]) * CW'(K_VEC[idx_q*4 +: 4]);
    hit = lhs > rhs;
    ws = WS_VEC[idx_q*8 +: 8];
    add = {acc_q[11], acc_q} + {{5{ws[7]}}, ws};
    accept = in_valid && in_ready;
    bad = int'(in_ch) >= NUM_CH;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    feat_d = feat_q;
    base_d = base_q;
    ch_d = ch_q;
    out_ch_d = out_ch_q;
    out_sum_d = out_sum_q;
    out_valid_d = out_valid_q;
    err_d = err_q;
    alarm_d = alarm_q;
    cnt_d = cnt_q;
    if (!en) begin
      out_valid_d = 1'b0;
      err_d = accept && bad;
      case (state_q)
        IDLE: if (accept && !bad) begin
          state_d = SUM;
          idx_d = '0;
          acc_d = '0;
          feat_d = feat_bus;
          base_d = base_bus;
          ch_d = in_ch;
        end
        SUM: begin
          // Overflow of the 12-bit sum shows as disagreeing top bits; clamp toward the sign of the true sum.
          if (hit) acc_d = add[12] != add[11] ? (add[12] ? 12'sh800 : 12'sh7FF) : add[11:0];
          idx_d = idx_q + 3'd1;
          state_d = idx_q == 3'(NUM_FEAT - 1) ? UPDATE : SUM;
        end
        UPDATE: begin
          state_d = IDLE;
          out_valid_d = 1'b1;
          out_ch_d = ch_q;
          out_sum_d = acc_q;
          for (int c = 0; c < NUM_CH; c++) if (4'(c) == ch_q) begin
            if (acc_q >= SUM_TH) cnt_d[c] = cnt_q[c] == 8'(HOLD) ? cnt_q[c] : cnt_q[c] + 8'd1;
`ifdef SEIZURE_DECISION_HYST_EN
            else cnt_d[c] = cnt_q[c] == 8'd0 ? 8'd0 : cnt_q[c] - 8'd1;
`else
            else cnt_d[c] = 8'd0;
`endif
            alarm_d[c] = cnt_d[c] == 8'(HOLD) ? 1'b1 : cnt_d[c] == 8'd0 ? 1'b0 : alarm_q[c];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    in_ready = state_q == IDLE && !en;
    out_valid = out_valid_q;
    out_ch = out_ch_q;
    out_sum = out_sum_q;
    alarm = alarm_q;
    err = err_q;
  end
endmodule
